// File: rtl/mul_seq_pkg.sv
// Shared definitions for the iterative nibble-serial multiplier.
// Contents:
//   NIB_W   - width of the slice handled by the 4x4 core
//   state_e - controller states (IDLE, BUSY, DONE)
//   steps() - number of core uses needed for a W x W multiply
package mul_seq_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int steps(input int w);
    return (w / NIB_W) * (w / NIB_W);
  endfunction

endpackage

// File: rtl/daddamul.sv
// 4x4 unsigned Dadda multiplier, purely combinational.
// Ports:
//   a [3:0] - multiplicand
//   b [3:0] - multiplier
//   p [7:0] - product a*b
// Reduction runs in two Dadda stages (height 4 -> 3 -> 2), followed by
// one 8-bit carry-propagate add of the two remaining rows.
module daddamul (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  // The return value packs {carry, sum}.
  function automatic logic [1:0] ha(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  function automatic logic [1:0] fa(input logic x, input logic y, input logic z);
    return {(x & y) | (z & (x ^ y)), x ^ y ^ z};
  endfunction

  logic [3:0] pp [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        pp[i][j] = a[i] & b[j];
      end
    end
  end

  // Stage 1: trim columns 3 and 4 down to height 3.
  logic s3a, c4a, s4a, c5a;
  assign {c4a, s3a} = ha(pp[3][0], pp[2][1]);
  assign {c5a, s4a} = ha(pp[3][1], pp[2][2]);

  // Stage 2: trim every column down to height 2.
  logic s2, c3b, s3, c4b, s4, c5b, s5, c6;
  assign {c3b, s2} = ha(pp[2][0], pp[1][1]);
  assign {c4b, s3} = fa(s3a, pp[1][2], pp[0][3]);
  assign {c5b, s4} = fa(s4a, pp[1][3], c4a);
  assign {c6,  s5} = fa(pp[3][2], pp[2][3], c5a);

  logic [7:0] row0, row1;
  assign row0 = {1'b0, pp[3][3], s5, s4, s3, s2, pp[1][0], pp[0][0]};
  assign row1 = {1'b0, c6, c5b, c4b, c3b, pp[0][2], pp[0][1], 1'b0};
  assign p    = row0 + row1;

endmodule

// File: rtl/dadda_seq_mul.sv
// Iterative W x W unsigned multiplier that reuses a single 4x4 Dadda core.
// One nibble pair is multiplied per cycle. The 8-bit partial product is
// shifted into place and added into a 2W-bit accumulator.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid / in_ready - operand handshake (accepted only in IDLE)
//   in_a, in_b [W-1:0]  - unsigned operands
//   out_valid/out_ready - result handshake (result held while stalled)
//   out_p [2W-1:0]      - product
//   busy                - high while a job is in flight or waiting to drain
module dadda_seq_mul
  import mul_seq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_p,
  output logic           busy
);

  localparam int NIB   = W / NIB_W;
  localparam int STEPS = steps(W);
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int PW    = 2 * W;

  if (W != 4 && W != 8 && W != 12 && W != 16) begin : g_bad_width
    $error("dadda_seq_mul: W must be 4, 8, 12 or 16");
  end

  state_e        state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [3:0]    core_a, core_b;
  logic [7:0]    core_p;
  logic [PW-1:0] pp_shifted;
  int unsigned   i_idx, j_idx;

  // The counter walks the multiplicand nibbles fastest, then steps the
  // multiplier nibble. Shifts select the nibbles so that every width
  // uses the same datapath without variable-index part selects.
  always_comb begin
    i_idx      = 32'(cnt_q) % NIB;
    j_idx      = 32'(cnt_q) / NIB;
    core_a     = 4'(a_q >> (NIB_W * i_idx));
    core_b     = 4'(b_q >> (NIB_W * j_idx));
    pp_shifted = PW'(core_p) << (NIB_W * (i_idx + j_idx));
  end

  daddamul u_core (
    .a (core_a),
    .b (core_b),
    .p (core_p)
  );

  // The accumulator never wraps because partial sums stay below the final
  // product, and that product fits in 2W bits.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d = acc_q + pp_shifted;
        if (cnt_q == CW'(STEPS - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_p     = acc_q;

endmodule

// File: tb/tb_dadda_seq_mul.sv
// Self-checking bench for dadda_seq_mul. A W=8 instance takes the directed
// table, backpressure, busy-toggle and reset sequences plus a random sweep.
// A W=16 instance takes its own random sweep. Expected products are
// queued at issue time and popped when the result handshake completes.
module tb_dadda_seq_mul;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [7:0]  in_a8, in_b8;
  logic [15:0] out_p8;

  logic        in_valid16, in_ready16, out_valid16, out_ready16, busy16;
  logic [15:0] in_a16, in_b16;
  logic [31:0] out_p16;

  dadda_seq_mul #(.W(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .in_a      (in_a8),
    .in_b      (in_b8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .out_p     (out_p8),
    .busy      (busy8)
  );

  dadda_seq_mul #(.W(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .in_a      (in_a16),
    .in_b      (in_b16),
    .out_valid (out_valid16),
    .out_ready (out_ready16),
    .out_p     (out_p16),
    .busy      (busy16)
  );

  int errors = 0;
  int checks = 0;

  logic [15:0] q8  [$];
  logic [31:0] q16 [$];

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t vecs [7];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
    int guard = 0;
    while (!in_ready8 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    in_a8     = a;
    in_b8     = b;
    in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    q8.push_back(p);
  endtask

  task automatic waitValid8(output int lat);
    lat = 0;
    while (!out_valid8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Compares the held result against the oldest queued expectation, then
  // lets the handshake complete and confirms the block is idle again.
  task automatic collect8(input string name);
    logic [15:0] exp;
    checkOutput({name, " out_valid"}, 32'(out_valid8), 32'd1);
    exp = (q8.size() != 0) ? q8.pop_front() : 16'hxxxx;
    checkOutput({name, " out_p"}, 32'(out_p8), 32'(exp));
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    checkOutput({name, " valid drop"}, 32'(out_valid8), 32'd0);
    checkOutput({name, " ready back"}, 32'(in_ready8), 32'd1);
  endtask

  task automatic runJob(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p, input string name);
    int lat;
    applyStimulus(a, b, p);
    waitValid8(lat);
    checkOutput({name, " latency"}, 32'(lat), 32'd4);
    collect8(name);
  endtask

  task automatic sweep8(input int n);
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    logic [7:0]  a, b;
    logic [15:0] exp;
    while (got < n && cyc < n * 40) begin
      @(negedge clk);
      cyc++;
      in_valid8 = 1'b0;
      if (sent < n && in_ready8) begin
        a = 8'($urandom);
        b = 8'($urandom);
        in_a8 = a;
        in_b8 = b;
        in_valid8 = 1'b1;
        q8.push_back({8'h00, a} * {8'h00, b});
        sent++;
      end
      out_ready8 = ($urandom_range(0, 3) != 0);
      if (out_valid8 && out_ready8) begin
        exp = (q8.size() != 0) ? q8.pop_front() : 16'hxxxx;
        checkOutput("sweep8 out_p", 32'(out_p8), 32'(exp));
        got++;
      end
    end
    @(negedge clk);
    in_valid8  = 1'b0;
    out_ready8 = 1'b1;
    checkOutput("sweep8 result count", 32'(got), 32'(n));
    q8.delete();
  endtask

  task automatic sweep16(input int n);
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    logic [15:0] a, b;
    logic [31:0] exp;
    while (got < n && cyc < n * 60) begin
      @(negedge clk);
      cyc++;
      in_valid16 = 1'b0;
      if (sent < n && in_ready16) begin
        a = 16'($urandom);
        b = 16'($urandom);
        if (sent == 0) begin
          a = 16'hFFFF;
          b = 16'hFFFF;
        end
        in_a16 = a;
        in_b16 = b;
        in_valid16 = 1'b1;
        q16.push_back({16'h0000, a} * {16'h0000, b});
        sent++;
      end
      out_ready16 = ($urandom_range(0, 3) != 0);
      if (out_valid16 && out_ready16) begin
        exp = (q16.size() != 0) ? q16.pop_front() : 32'hxxxxxxxx;
        checkOutput("sweep16 out_p", out_p16, exp);
        got++;
      end
    end
    @(negedge clk);
    in_valid16  = 1'b0;
    out_ready16 = 1'b1;
    checkOutput("sweep16 result count", 32'(got), 32'(n));
    q16.delete();
  endtask

  initial begin
    int lat;

    vecs[0] = '{a: 8'h12, b: 8'h34, p: 16'h03A8};
    vecs[1] = '{a: 8'hFF, b: 8'hFF, p: 16'hFE01};
    vecs[2] = '{a: 8'h00, b: 8'hA7, p: 16'h0000};
    vecs[3] = '{a: 8'h0F, b: 8'h0F, p: 16'h00E1};
    vecs[4] = '{a: 8'hA7, b: 8'h00, p: 16'h0000};
    vecs[5] = '{a: 8'h80, b: 8'h02, p: 16'h0100};
    vecs[6] = '{a: 8'h01, b: 8'hFF, p: 16'h00FF};

    rst_n       = 1'b0;
    in_valid8   = 1'b0;
    in_a8       = '0;
    in_b8       = '0;
    out_ready8  = 1'b1;
    in_valid16  = 1'b0;
    in_a16      = '0;
    in_b16      = '0;
    out_ready16 = 1'b1;

    #12;
    checkOutput("reset in_ready", 32'(in_ready8), 32'd1);
    checkOutput("reset out_valid", 32'(out_valid8), 32'd0);
    checkOutput("reset out_p", 32'(out_p8), 32'd0);
    checkOutput("reset busy", 32'(busy8), 32'd0);
    checkOutput("reset in_ready16", 32'(in_ready16), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] directed table");
    for (int k = 0; k < 7; k++) begin
      runJob(vecs[k].a, vecs[k].b, vecs[k].p, $sformatf("vec%0d", k));
    end

    $display("[TB] backpressure");
    out_ready8 = 1'b0;
    applyStimulus(8'h12, 8'h34, 16'h03A8);
    waitValid8(lat);
    checkOutput("stall latency", 32'(lat), 32'd4);
    for (int k = 0; k < 10; k++) begin
      checkOutput("stall out_valid", 32'(out_valid8), 32'd1);
      checkOutput("stall out_p", 32'(out_p8), 32'h03A8);
      checkOutput("stall in_ready", 32'(in_ready8), 32'd0);
      @(posedge clk); #1;
    end
    collect8("stall release");

    $display("[TB] inputs toggled while busy");
    applyStimulus(8'h12, 8'h34, 16'h03A8);
    for (int k = 0; k < 3; k++) begin
      in_valid8 = 1'($urandom);
      in_a8     = 8'($urandom);
      in_b8     = 8'($urandom);
      checkOutput("busy in_ready", 32'(in_ready8), 32'd0);
      @(posedge clk); #1;
    end
    in_valid8 = 1'b1;
    in_a8     = 8'hFF;
    in_b8     = 8'hFF;
    checkOutput("done in_ready", 32'(in_ready8), 32'd0);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    collect8("busy toggle");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("no second job", 32'(busy8), 32'd0);

    $display("[TB] reset mid-operation");
    applyStimulus(8'hAB, 8'hCD, 16'h88EF);
    @(posedge clk); #1;
    checkOutput("pre-reset busy", 32'(busy8), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async out_valid", 32'(out_valid8), 32'd0);
    checkOutput("async out_p", 32'(out_p8), 32'd0);
    checkOutput("async busy", 32'(busy8), 32'd0);
    checkOutput("async in_ready", 32'(in_ready8), 32'd1);
    q8.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    runJob(8'h0F, 8'h0F, 16'h00E1, "post reset");

    $display("[TB] random sweeps");
    sweep8(400);
    sweep16(300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
